// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master to 1-slave Wishbone classic round-robin arbiter.
// A grant is locked for as long as the owner holds cyc, so multi-beat and
// locked cycles are never split between masters.
// Optional bus watchdog is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_MASTERS-1:0]                m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                m_stb_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_wstrb_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_data_i,
    output logic [DATA_WIDTH-1:0]                 m_data_o,
    output logic [NUM_MASTERS-1:0]                m_ack_o,
    output logic [NUM_MASTERS-1:0]                m_err_o,
    output logic                                  s_cyc_o,
    output logic                                  s_stb_o,
    output logic                                  s_we_o,
    output logic [DATA_WIDTH/8-1:0]               s_wstrb_o,
    output logic [ADDR_WIDTH-1:0]                 s_addr_o,
    output logic [DATA_WIDTH-1:0]                 s_data_o,
    input  logic [DATA_WIDTH-1:0]                 s_data_i,
    input  logic                                  s_ack_i,
    output logic [NUM_MASTERS-1:0]                grant_o
);

    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN   = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [1:0] S_ABORT = 2'd2;
`endif

    // Reject configurations the datapath slicing cannot support.
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("wb_rr_arbiter: illegal parameter set");
    end

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [IW-1:0]          r_last;
    logic [IW-1:0]          w_last_nxt;
    logic [IW-1:0]          w_sel;
    logic                   w_found;
    logic                   w_cyc_g;
    logic                   w_stb_g;
    logic                   w_timeout;

    assign w_cyc_g  = m_cyc_i[r_last];
    assign w_stb_g  = w_cyc_g & m_stb_i[r_last];
    assign grant_o  = r_grant;
    assign m_data_o = s_data_i;

    // Round-robin pick: first requester after the last granted master.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
            if (!w_found && m_cyc_i[IW'((32'(r_last) + 32'(i)) % NUM_MASTERS)]) begin
                w_found = 1'b1;
                w_sel   = IW'((32'(r_last) + 32'(i)) % NUM_MASTERS);
            end
        end
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= IW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the owner while its cyc stays high.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_OWN;
                    w_grant_nxt = NUM_MASTERS'(1) << w_sel;
                    w_last_nxt  = w_sel;
                end
            end
            S_OWN: begin
                if (!w_cyc_g) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (w_timeout) begin
                    w_state_nxt = S_ABORT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            S_ABORT: begin
                if (!w_cyc_g) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                end
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Slave-side mux and ack routing; everything is quiet outside OWN.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_wstrb_o = '0;
        s_addr_o  = '0;
        s_data_o  = '0;
        m_ack_o   = '0;
        if (r_state == S_OWN) begin
            s_cyc_o   = w_cyc_g;
            s_stb_o   = w_stb_g;
            s_we_o    = m_we_i[r_last];
            s_wstrb_o = m_wstrb_i[32'(r_last)*SW +: SW];
            s_addr_o  = m_addr_i[32'(r_last)*ADDR_WIDTH +: ADDR_WIDTH];
            s_data_o  = m_data_i[32'(r_last)*DATA_WIDTH +: DATA_WIDTH];
            // Ack passes with an active strobe, or as a stray ack on the cyc-drop cycle.
            m_ack_o[r_last] = s_ack_i & (w_stb_g | ~w_cyc_g);
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0]          r_wd_cnt;
    logic [NUM_MASTERS-1:0] r_err;

    assign w_timeout = (r_state == S_OWN) && w_stb_g && !s_ack_i
                       && (r_wd_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign m_err_o   = r_err;

    // Watchdog: count unacked strobe cycles, raise a one-cycle error on expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
            r_err    <= '0;
        end else begin
            r_err <= w_timeout ? r_grant : '0;
            if (r_state != S_OWN || s_ack_i || w_timeout) begin
                r_wd_cnt <= '0;
            end else if (w_stb_g) begin
                r_wd_cnt <= r_wd_cnt + CW'(1);
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign m_err_o   = '0;
`endif

endmodule
